// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
//   Shared types and constants for the two-requester round-robin mux arbiter.
//   state_t   : arbiter ownership state (IDLE, OWN0, OWN1)
//   SEL_REQ0/1: mux select values that route requester 0 / 1 to the output
//   CNT_W     : width of the per-grant burst counter
// ---------------------------------------------------------------------------
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic SEL_REQ0 = 1'b0;
    localparam logic SEL_REQ1 = 1'b1;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mux2_arbiter_ymux2.sv
// ---------------------------------------------------------------------------
// yMux2
//   Plain 2:1 datapath multiplexer shared by the two requesters.
//   Ports:
//     a  in  WIDTH  input selected when c = 0
//     b  in  WIDTH  input selected when c = 1
//     c  in  1      select
//     z  out WIDTH  c ? b : a
// ---------------------------------------------------------------------------
module yMux2 #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] z
);

    assign z = c ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_arbiter
//   Round-robin controller that owns the select line of a shared 2:1 data mux
//   (yMux2). One requester is granted at a time and its words are forwarded
//   over a valid/ready link. Each grant is limited to MAX_BURST transfers when
//   the other requester is waiting.
//
//   Parameters:
//     WIDTH      data width of each requester and of out_data
//     MAX_BURST  transfers per grant before forced hand-over (1..15)
//
//   Ports:
//     clk        in   1      clock, rising edge
//     rst_n      in   1      asynchronous active-low reset
//     req0/1     in   1      requester has a word (held until its ack)
//     data0/1    in   WIDTH  requester data
//     ack0/1     out  1      requester word accepted this cycle
//     out_data   out  WIDTH  sel ? data1 : data0 (combinational)
//     out_valid  out  1      owner's req while granted
//     out_ready  in   1      consumer accepts when out_valid & out_ready
//     gnt        out  2      one-hot owner, 00 when idle
//     sel        out  1      mux select (1 = requester 1)
//     lock0/1    in   1      only with MUX_ARB_LOCK_EN: owner keeps the grant
//                            past MAX_BURST while its lock is high
//
//   Build option: define MUX_ARB_LOCK_EN to add the lock0/lock1 inputs.
// ---------------------------------------------------------------------------
module mux2_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
`ifdef MUX_ARB_LOCK_EN
    input  logic             lock0,
    input  logic             lock1,
`endif
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       gnt,
    output logic             sel
);

    localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state;
    state_t           state_nxt;
    state_t           other_state;
    logic             last;
    logic             last_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic owner1;
    logic own_req;
    logic other_req;
    logic own_lock;
    logic lock0_eff;
    logic lock1_eff;
    logic transfer;

`ifdef MUX_ARB_LOCK_EN
    assign lock0_eff = lock0;
    assign lock1_eff = lock1;
`else
    assign lock0_eff = 1'b0;
    assign lock1_eff = 1'b0;
`endif

    // Owner-relative views so OWN0 and OWN1 share one set of next-state rules.
    assign owner1      = (state == OWN1);
    assign own_req     = owner1 ? req1 : req0;
    assign other_req   = owner1 ? req0 : req1;
    assign own_lock    = owner1 ? lock1_eff : lock0_eff;
    assign other_state = owner1 ? OWN0 : OWN1;
    assign transfer    = ack0 | ack1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (req0 && req1) begin
                    state_nxt = last ? OWN0 : OWN1;
                end else if (req0) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    state_nxt = other_req ? other_state : IDLE;
                    last_nxt  = owner1;
                    cnt_nxt   = '0;
                end else if (transfer) begin
                    // cnt >= BURST_LAST also catches a counter that saturated
                    // at BURST_MAX under lock once the lock is released.
                    if ((cnt >= BURST_LAST) && !own_lock) begin
                        cnt_nxt = '0;
                        if (other_req) begin
                            state_nxt = other_state;
                            last_nxt  = owner1;
                        end
                    end else if (cnt != BURST_MAX) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        gnt       = '0;
        sel       = SEL_REQ0;
        out_valid = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        case (state)
            OWN0: begin
                gnt       = 2'b01;
                sel       = SEL_REQ0;
                out_valid = req0;
                ack0      = req0 & out_ready;
            end
            OWN1: begin
                gnt       = 2'b10;
                sel       = SEL_REQ1;
                out_valid = req1;
                ack1      = req1 & out_ready;
            end
            default: ;
        endcase
    end

    yMux2 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .a(data0),
        .b(data1),
        .c(sel),
        .z(out_data)
    );

endmodule
